// File: rtl/macro_fetch_pkg.sv
// Shared definitions for the macroinstruction fetch unit: FSM states,
// address widths and the byte/halfword select encodings.
package macro_fetch_pkg;

    localparam int LC_W = 26;
    localparam int WA_W = LC_W - 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    localparam logic SEL_HALF = 1'b0;
    localparam logic SEL_BYTE = 1'b1;

endpackage

// File: rtl/macro_fetch_isel.sv
// Combinational extraction of the current macroinstruction from the
// buffered 32-bit word, in halfword or zero-extended byte form.
module macro_isel
    import macro_fetch_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  sel,
    input  logic        byte_mode,
    output logic [15:0] inst
);

    always_comb begin
        inst = '0;
        if (byte_mode == SEL_BYTE) begin
            case (sel)
                2'd0:    inst = {8'b0, word[7:0]};
                2'd1:    inst = {8'b0, word[15:8]};
                2'd2:    inst = {8'b0, word[23:16]};
                default: inst = {8'b0, word[31:24]};
            endcase
        end else begin
            inst = sel[1] ? word[31:16] : word[15:0];
        end
    end

endmodule

// File: rtl/macro_fetch.sv
// Single-word macroinstruction fetch buffer: holds the word covering lc and
// requests a new one from memory whenever lc leaves it.
module macro_fetch #(
    parameter int LC_W = macro_fetch_pkg::LC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LC_W-1:0]   lc,
    input  logic              lc_byte_mode,
    input  logic              lc_load,
    output logic              mem_req,
    output logic [LC_W-3:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    input  logic              mem_err,
    output logic              needfetch,
    output logic [15:0]       inst,
    output logic              inst_valid,
    output logic              fetch_err
);

    import macro_fetch_pkg::*;

    localparam int TAG_W = LC_W - 2;

    fetch_state_t     state;
    logic [31:0]      wbuf;
    logic [TAG_W-1:0] wtag;
    logic [TAG_W-1:0] rtag;
    logic             wvalid;
    logic             stale;
    logic [TAG_W-1:0] lc_tag;

    assign lc_tag     = lc[LC_W-1:2];
    assign needfetch  = !wvalid || (wtag != lc_tag);
    assign inst_valid = wvalid && !needfetch && (state != ST_ERR);
    assign mem_addr   = rtag;

    macro_isel u_isel (
        .word      (wbuf),
        .sel       (lc[1:0]),
        .byte_mode (lc_byte_mode),
        .inst      (inst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            mem_req   <= 1'b0;
            wvalid    <= 1'b0;
            stale     <= 1'b0;
            fetch_err <= 1'b0;
            wbuf      <= '0;
            wtag      <= '0;
            rtag      <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (needfetch && !lc_load) begin
                        state   <= ST_REQ;
                        mem_req <= 1'b1;
                        rtag    <= lc_tag;
                        stale   <= 1'b0;
                    end
                end

                // The request stays up until acked; an lc_load only marks
                // the returning word as unusable.
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (stale || lc_load) begin
                            wvalid <= 1'b0;
                            state  <= ST_EMPTY;
                        end else if (mem_err) begin
                            fetch_err <= 1'b1;
                            wvalid    <= 1'b0;
                            state     <= ST_ERR;
                        end else begin
                            wbuf   <= mem_data;
                            wtag   <= rtag;
                            wvalid <= 1'b1;
                            state  <= ST_FULL;
                        end
                    end else if (lc_load) begin
                        stale <= 1'b1;
                    end
                end

                // Old word stays valid while the replacement is in flight.
                ST_FULL: begin
                    if (lc_load) begin
                        wvalid <= 1'b0;
                        state  <= ST_EMPTY;
                    end else if (needfetch) begin
                        state   <= ST_REQ;
                        mem_req <= 1'b1;
                        rtag    <= lc_tag;
                        stale   <= 1'b0;
                    end
                end

                default: begin
                    if (lc_load) begin
                        fetch_err <= 1'b0;
                        wvalid    <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macro_fetch.sv
// Randomized and directed bench for macro_fetch against a flag-based
// behavioural model of the fetch buffer.
module tb_macro_fetch;

    logic        clk;
    logic        reset;
    logic [25:0] lc;
    logic        lc_byte_mode;
    logic        lc_load;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        mem_err;
    logic        needfetch;
    logic [15:0] inst;
    logic        inst_valid;
    logic        fetch_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: a pending request (with its tag and stale mark), a buffered
    // word (with its tag and validity) and a fault flag.
    logic        m_pend, m_stale, m_bv, m_fault;
    logic [23:0] m_ptag, m_btag;
    logic [31:0] m_word;

    macro_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .lc           (lc),
        .lc_byte_mode (lc_byte_mode),
        .lc_load      (lc_load),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .mem_err      (mem_err),
        .needfetch    (needfetch),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_needfetch();
        return !m_bv || (m_btag != lc[25:2]);
    endfunction

    function automatic logic [31:0] m_inst();
        if (lc_byte_mode)
            return (m_word >> (8 * int'(lc[1:0]))) & 32'h0000_00FF;
        return (m_word >> (16 * int'(lc[1]))) & 32'h0000_FFFF;
    endfunction

    task automatic model_compare();
        logic nf;
        nf = m_needfetch();
        chk("needfetch",  32'(needfetch),  32'(nf));
        chk("inst",       32'(inst),       m_inst());
        chk("inst_valid", 32'(inst_valid), 32'(m_bv && !nf && !m_fault));
        chk("mem_req",    32'(mem_req),    32'(m_pend));
        chk("mem_addr",   32'(mem_addr),   32'(m_ptag));
        chk("fetch_err",  32'(fetch_err),  32'(m_fault));
    endtask

    task automatic model_update();
        logic nf;
        nf = m_needfetch();
        if (reset) begin
            m_pend = 0; m_stale = 0; m_bv = 0; m_fault = 0;
            m_ptag = '0; m_btag = '0; m_word = '0;
        end else if (m_fault) begin
            if (lc_load) begin
                m_fault = 0;
                m_bv    = 0;
            end
        end else if (m_pend) begin
            if (mem_ack) begin
                m_pend = 0;
                if (m_stale || lc_load) m_bv = 0;
                else if (mem_err) begin
                    m_fault = 1;
                    m_bv    = 0;
                end else begin
                    m_bv   = 1;
                    m_word = mem_data;
                    m_btag = m_ptag;
                end
            end else if (lc_load) begin
                m_stale = 1;
            end
        end else begin
            if (lc_load) m_bv = 0;
            else if (nf) begin
                m_pend  = 1;
                m_ptag  = lc[25:2];
                m_stale = 0;
            end
        end
    endtask

    task automatic set_in(input logic r, input logic [25:0] l, input logic bm,
                          input logic ld, input logic a, input logic [31:0] d,
                          input logic e);
        reset = r; lc = l; lc_byte_mode = bm; lc_load = ld;
        mem_ack = a; mem_data = d; mem_err = e;
        #1;
    endtask

    task automatic cyc();
        model_compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    logic [25:0] base_tbl [4] = '{26'h100, 26'h104, 26'h1FC, 26'h200};
    logic [7:0]  byte_exp [4] = '{8'h34, 8'h12, 8'hEF, 8'hBE};

    initial begin
        logic [25:0] nlc;
        int r;
        m_pend = 0; m_stale = 0; m_bv = 0; m_fault = 0;
        m_ptag = '0; m_btag = '0; m_word = '0;
        reset = 1; lc = '0; lc_byte_mode = 0; lc_load = 0;
        mem_ack = 0; mem_data = '0; mem_err = 0;
        @(negedge clk);

        set_in(1, 26'h000, 0, 0, 0, 0, 0); cyc();

        // Post-reset outputs, then first fetch of lc=0x100.
        set_in(0, 26'h100, 0, 0, 0, 0, 0);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_inst",       32'(inst),       32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_needfetch",  32'(needfetch),  32'd1);
        chk("rst_fetch_err",  32'(fetch_err),  32'd0);
        cyc();
        set_in(0, 26'h100, 0, 0, 1, 32'hBEEF1234, 0);
        chk("req1_mem_req",  32'(mem_req),  32'd1);
        chk("req1_mem_addr", 32'(mem_addr), 32'h40);
        cyc();
        set_in(0, 26'h100, 0, 0, 0, 0, 0);
        chk("half_lo",       32'(inst),       32'h1234);
        chk("half_lo_valid", 32'(inst_valid), 32'd1);
        cyc();
        set_in(0, 26'h102, 0, 0, 0, 0, 0);
        chk("half_hi", 32'(inst), 32'hBEEF);
        cyc();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 26'h100 + 26'(i), 1, 0, 0, 0, 0);
            chk("byte_inst",    32'(inst),    32'(byte_exp[i]));
            chk("byte_mem_req", 32'(mem_req), 32'd0);
            cyc();
        end

        // lc_load during an outstanding request discards the returned word.
        set_in(0, 26'h1FE, 0, 0, 0, 0, 0);
        chk("miss_needfetch", 32'(needfetch), 32'd1);
        cyc();
        set_in(0, 26'h300, 0, 1, 0, 0, 0);
        chk("stale_mem_addr", 32'(mem_addr), 32'h7F);
        cyc();
        set_in(0, 26'h300, 0, 0, 1, 32'hDEADBEEF, 0);
        chk("stale_mem_req", 32'(mem_req), 32'd1);
        cyc();
        set_in(0, 26'h300, 0, 0, 0, 0, 0);
        chk("discard_mem_req", 32'(mem_req),    32'd0);
        chk("discard_valid",   32'(inst_valid), 32'd0);
        cyc();
        set_in(0, 26'h300, 0, 0, 0, 0, 0);
        chk("refetch_mem_req",  32'(mem_req),  32'd1);
        chk("refetch_mem_addr", 32'(mem_addr), 32'hC0);
        cyc();

        // Faulted read: sticky error, no requests until lc_load.
        set_in(0, 26'h300, 0, 0, 1, 32'h11112222, 1); cyc();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 26'h300, 0, 0, 0, 0, 0);
            chk("err_fetch_err", 32'(fetch_err),  32'd1);
            chk("err_mem_req",   32'(mem_req),    32'd0);
            chk("err_valid",     32'(inst_valid), 32'd0);
            cyc();
        end
        set_in(0, 26'h300, 0, 1, 0, 0, 0); cyc();
        set_in(0, 26'h300, 0, 0, 0, 0, 0);
        chk("clr_fetch_err", 32'(fetch_err), 32'd0);
        cyc();
        set_in(0, 26'h300, 0, 0, 1, 32'hCAFEF00D, 0);
        chk("restart_mem_req", 32'(mem_req), 32'd1);
        cyc();

        // Word boundary crossing 0x1FE -> 0x200 while FULL.
        set_in(0, 26'h1FC, 0, 0, 0, 0, 0); cyc();
        set_in(0, 26'h1FC, 0, 0, 1, 32'h55667788, 0); cyc();
        set_in(0, 26'h1FE, 0, 0, 0, 0, 0);
        chk("cross_pre_inst", 32'(inst), 32'h5566);
        cyc();
        set_in(0, 26'h200, 0, 0, 0, 0, 0);
        chk("cross_needfetch", 32'(needfetch), 32'd1);
        cyc();
        set_in(0, 26'h200, 0, 0, 0, 0, 0);
        chk("cross_mem_req",  32'(mem_req),  32'd1);
        chk("cross_mem_addr", 32'(mem_addr), 32'h80);
        cyc();

        // Reset mid-request; the late ack must be ignored.
        set_in(1, 26'h200, 0, 0, 0, 0, 0); cyc();
        set_in(0, 26'h200, 0, 0, 1, 32'h99999999, 0);
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        cyc();
        set_in(0, 26'h200, 0, 0, 0, 0, 0);
        chk("rstmid_refetch", 32'(mem_req),    32'd1);
        chk("rstmid_valid",   32'(inst_valid), 32'd0);
        cyc();

        // Random traffic, including lc wrapping through all-ones.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 9)
                nlc = lc + 26'($urandom_range(0, 2));
            else if (r < 13)
                nlc = base_tbl[int'($urandom_range(0, 3))] + 26'($urandom_range(0, 3));
            else
                nlc = 26'h3FFFFFC + 26'($urandom_range(0, 3));
            set_in($urandom_range(0, 199) == 0, nlc, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                   $urandom, $urandom_range(0, 15) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/macro_fetch.md
MACRO_FETCH -- requirements
Module: macro_fetch

Interface
REQ-001: Parameter LC_W, default 26, is the LC byte-address width; word address width is LC_W-2.
REQ-002: clk  in  1  system clock; all state updates on its rising edge.
REQ-003: reset  in  1  synchronous, active-high reset.
REQ-004: lc  in  LC_W  current location counter (byte address); lc[1:0] selects the byte/halfword within a word.
REQ-005: lc_byte_mode  in  1  1 = byte instructions; 0 = halfword instructions.
REQ-006: lc_load  in  1  single-cycle pulse: LC written from the datapath (destlc); flushes the buffer.
REQ-007: mem_req  out  1  memory read request; held high until mem_ack.
REQ-008: mem_addr  out  LC_W-2  word address of the outstanding request.
REQ-009: mem_ack  in  1  single-cycle read completion.
REQ-010: mem_data  in  32  read data, valid when mem_ack=1.
REQ-011: mem_err  in  1  read fault, qualified by mem_ack.
REQ-012: needfetch  out  1  the buffered word does not cover lc.
REQ-013: inst  out  16  selected macroinstruction.
REQ-014: inst_valid  out  1  inst is correct for the current lc.
REQ-015: fetch_err  out  1  sticky fetch fault.

Function
REQ-016: Internal state: wbuf[31:0], wtag[LC_W-3:0], wvalid, stale, and rtag (the request tag).
REQ-017: FSM states are EMPTY, REQ, FULL and ERR.
REQ-018: needfetch = !wvalid | (wtag != lc[LC_W-1:2]); this output is combinational.
REQ-019: inst_valid = wvalid & !needfetch & (state != ERR).
REQ-020: Halfword mode: inst = lc[1] ? wbuf[31:16] : wbuf[15:0]; lc[0] is ignored.
REQ-021: Byte mode: inst = {8'b0, byte lc[1:0] of wbuf}, where byte 0 = wbuf[7:0].
REQ-022: EMPTY: if needfetch and !lc_load, go to REQ, set rtag <= lc[LC_W-1:2] and set stale <= 0.
REQ-023: mem_req = (state == REQ), and mem_addr = rtag; neither changes until mem_ack.
REQ-024: Latency: mem_req rises one cycle after needfetch is seen in EMPTY or FULL.
REQ-025: Latency: inst_valid rises the cycle after mem_ack, provided lc still matches rtag.
REQ-026: REQ, mem_ack with !mem_err and !stale: wbuf <= mem_data, wtag <= rtag, wvalid <= 1, go to FULL.
REQ-027: REQ, mem_ack with stale, or with lc_load in the same cycle: discard the data, wvalid <= 0, go to EMPTY.
REQ-028: REQ, mem_ack with mem_err and !stale: fetch_err <= 1, wvalid <= 0, go to ERR.
REQ-029: REQ, lc_load without mem_ack: stale <= 1; the request is never withdrawn.
REQ-030: FULL, lc_load: wvalid <= 0, go to EMPTY; this takes priority over a tag mismatch.
REQ-031: FULL, needfetch without lc_load: go directly to REQ and capture rtag; wbuf is retained until the new word arrives.
REQ-032: Tag wrap: lc crossing a word boundary, including an all-ones-to-zero wrap, is an ordinary tag mismatch.
REQ-033: ERR: mem_req = 0 and no requests are issued.
REQ-034: ERR: lc_load clears fetch_err and wvalid and goes to EMPTY.
REQ-035: mem_ack outside REQ is ignored.

Reset
REQ-036: On reset: state = EMPTY, wvalid = 0, stale = 0, fetch_err = 0, wbuf = 0, wtag = 0, rtag = 0.
REQ-037: Consequently after reset: mem_req = 0, inst = 0, inst_valid = 0 and needfetch = 1.
REQ-038: Reset asserted mid-request abandons the request; a later mem_ack is ignored under REQ-035.

Structure
REQ-039: A shared package holds the FSM state enum, LC_W, the derived word-address width and the byte/halfword select encodings.
REQ-040: One sub-module, macro_isel, implements the combinational byte/halfword select of REQ-020 and REQ-021; all other logic is in macro_fetch.

Verification
REQ-041: Reset, then lc = 0x100, halfword mode -> mem_req = 1 with mem_addr = 0x40 the next cycle.
REQ-042: Then ack with data 0xBEEF1234 -> inst = 0x1234 and inst_valid = 1 the following cycle; with lc = 0x102, inst = 0xBEEF.
REQ-043: Byte mode, lc stepping 0x100..0x103 -> inst = 0x0034, 0x0012, 0x00EF, 0x00BE, with no new mem_req.
REQ-044: lc_load pulse while in REQ, then ack -> data discarded, state EMPTY, and a new request issued for the new lc.
REQ-045: Ack with mem_err = 1 -> fetch_err = 1, no further mem_req, inst_valid = 0; lc_load then clears fetch_err and a fetch restarts.
REQ-046: lc stepping from 0x1FE to 0x200 in FULL -> needfetch = 1 the same cycle, and mem_req with mem_addr = 0x80 the next cycle.
